// File: rtl/sdram_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdram_refresh_scheduler
// Brief    : SDRAM power-up init sequencer and periodic auto-refresh scheduler
// Revision : 1.0 - initial release
// ============================================================================
module sdram_refresh_scheduler #(
    parameter int CNT_W          = 16,
    parameter int T_POWERUP      = 20000,
    parameter int T_RP           = 3,
    parameter int T_RFC          = 9,
    parameter int T_MRD          = 2,
    parameter int T_REFI         = 780,
    parameter int INIT_REFRESHES = 8,
    parameter int MAX_PENDING    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    input  logic       cmd_ready,
    output logic       init_done,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PWRUP     = 4'd1,
        S_PRE       = 4'd2,
        S_WAIT_RP   = 4'd3,
        S_IREF      = 4'd4,
        S_WAIT_IRFC = 4'd5,
        S_LMR       = 4'd6,
        S_WAIT_MRD  = 4'd7,
        S_RUN       = 4'd8,
        S_REF       = 4'd9,
        S_WAIT_RFC  = 4'd10
    } state_t;

    localparam logic [1:0]       c_CMD_NOP  = 2'b00;
    localparam logic [1:0]       c_CMD_PRE  = 2'b01;
    localparam logic [1:0]       c_CMD_REF  = 2'b10;
    localparam logic [1:0]       c_CMD_LMR  = 2'b11;
    localparam logic [CNT_W-1:0] c_PWRUP    = CNT_W'(T_POWERUP);
    localparam logic [CNT_W-1:0] c_RP_M1    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] c_RFC_M1   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] c_MRD_M1   = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] c_REFI_M1  = CNT_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0] c_INIT_REF = CNT_W'(INIT_REFRESHES);
    localparam logic [3:0]       c_MAX_PEND = 4'(MAX_PENDING);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [CNT_W-1:0] r_iref_cnt;
    logic [CNT_W-1:0] r_refi_cnt;
    logic             w_xfer;
    logic             w_ref_xfer;
    logic             w_refi_run;
    logic             w_tick;

    assign w_xfer     = cmd_valid & cmd_ready;
    assign w_ref_xfer = w_xfer && (r_state == S_REF);
    assign w_refi_run = (r_state == S_RUN) || (r_state == S_REF) || (r_state == S_WAIT_RFC);
    assign w_tick     = w_refi_run && (r_refi_cnt == c_REFI_M1);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        case (r_state)
            S_IDLE: begin
                w_wait_cnt_nxt = '0;
                if (enable) w_state_nxt = S_PWRUP;
            end
            S_PWRUP: begin
                if (r_wait_cnt == c_PWRUP) begin
                    w_state_nxt    = S_PRE;
                    w_wait_cnt_nxt = '0;
                end
            end
            S_WAIT_RP: begin
                if (r_wait_cnt == c_RP_M1) begin
                    w_state_nxt    = S_IREF;
                    w_wait_cnt_nxt = '0;
                end
            end
            S_WAIT_IRFC: begin
                if (r_wait_cnt == c_RFC_M1) begin
                    w_state_nxt    = (r_iref_cnt < c_INIT_REF) ? S_IREF : S_LMR;
                    w_wait_cnt_nxt = '0;
                end
            end
            S_WAIT_MRD: begin
                if (r_wait_cnt == c_MRD_M1) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            // Going straight back to REF keeps owed refreshes T_RFC+1 apart
            S_WAIT_RFC: begin
                if (r_wait_cnt == c_RFC_M1) begin
                    w_state_nxt    = (pending != 4'd0) ? S_REF : S_RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            S_PRE: begin
                w_wait_cnt_nxt = '0;
                if (w_xfer) w_state_nxt = S_WAIT_RP;
            end
            S_IREF: begin
                w_wait_cnt_nxt = '0;
                if (w_xfer) w_state_nxt = S_WAIT_IRFC;
            end
            S_LMR: begin
                w_wait_cnt_nxt = '0;
                if (w_xfer) w_state_nxt = S_WAIT_MRD;
            end
            S_RUN: begin
                w_wait_cnt_nxt = '0;
                if (pending != 4'd0) w_state_nxt = S_REF;
            end
            S_REF: begin
                w_wait_cnt_nxt = '0;
                if (w_xfer) w_state_nxt = S_WAIT_RFC;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_iref_cnt <= '0;
            r_refi_cnt <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            init_done  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd        <= c_CMD_NOP;
        end else begin
            if (w_xfer && (r_state == S_IREF)) r_iref_cnt <= r_iref_cnt + 1'b1;

            if (r_state == S_WAIT_MRD)
                r_refi_cnt <= '0;
            else if (w_refi_run)
                r_refi_cnt <= w_tick ? '0 : r_refi_cnt + 1'b1;

            // A tick and a refresh on the same edge cancel out
            if (w_tick && !w_ref_xfer) begin
                if (pending == c_MAX_PEND) overflow <= 1'b1;
                else                       pending  <= pending + 1'b1;
            end else if (w_ref_xfer && !w_tick) begin
                pending <= pending - 1'b1;
            end

            if (r_state == S_RUN) init_done <= 1'b1;

            case (w_state_nxt)
                S_PRE:   begin cmd_valid <= 1'b1; cmd <= c_CMD_PRE; end
                S_IREF:  begin cmd_valid <= 1'b1; cmd <= c_CMD_REF; end
                S_REF:   begin cmd_valid <= 1'b1; cmd <= c_CMD_REF; end
                S_LMR:   begin cmd_valid <= 1'b1; cmd <= c_CMD_LMR; end
                default: begin cmd_valid <= 1'b0; cmd <= c_CMD_NOP; end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_refresh_scheduler
// Brief    : Directed self-checking bench for sdram_refresh_scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_refresh_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       enable = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       init_done;
    logic [3:0] pending;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = -1;
    int max_pend = 0;
    int xe;
    int n;
    logic [1:0] xc;

    sdram_refresh_scheduler #(
        .CNT_W(16), .T_POWERUP(10), .T_RP(2), .T_RFC(3), .T_MRD(2),
        .T_REFI(20), .INIT_REFRESHES(2), .MAX_PENDING(4)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .init_done(init_done), .pending(pending), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        e++;
        if (int'(pending) > max_pend) max_pend = int'(pending);
    endtask

    task automatic step_to(input int target);
        while (e < target) step();
    endtask

    // Edge number (relative to the enable edge) of the next command transfer
    task automatic next_xfer(input int max, output int edge_o, output logic [1:0] c_o);
        edge_o = -1;
        c_o    = 2'b00;
        for (int i = 0; i < max; i++) begin
            if (cmd_valid && cmd_ready) begin
                c_o = cmd;
                step();
                edge_o = e;
                return;
            end
            step();
        end
    endtask

    task automatic release_rst();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic start_init();
        enable = 1'b1;
        e = -1;
        step();
        enable = 1'b0;
    endtask

    task automatic wait_valid();
        n = 0;
        while (!cmd_valid && n < 40) begin step(); n++; end
    endtask

    task automatic wait_init_done();
        n = 0;
        while (!init_done && n < 40) begin step(); n++; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_init"}, init_done, 0);
        chk({tag, "_pend"}, pending, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic run_init(input string tag);
        start_init();
        wait_valid();
        chk({tag, "_first_valid_edge"}, e, 11);
        next_xfer(20, xe, xc); chk({tag, "_pre_edge"}, xe, 12); chk({tag, "_pre_cmd"}, xc, 1);
        next_xfer(20, xe, xc); chk({tag, "_iref1_edge"}, xe, 15); chk({tag, "_iref1_cmd"}, xc, 2);
        next_xfer(20, xe, xc); chk({tag, "_iref2_edge"}, xe, 19); chk({tag, "_iref2_cmd"}, xc, 2);
        next_xfer(20, xe, xc); chk({tag, "_lmr_edge"}, xe, 23); chk({tag, "_lmr_cmd"}, xc, 3);
        wait_init_done();
        chk({tag, "_init_done_edge"}, e, 26);
    endtask

    initial begin
        // Reset state, applied asynchronously before any clock edge
        #1 RST = 1'b1;
        #1 chk_all_zero("reset");
        release_rst();

        // Enable held low: nothing happens
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_quiet", {cmd_valid, init_done, pending, overflow}, 0);
        end

        // Init sequence and steady refresh
        run_init("init");
        max_pend = 0;
        next_xfer(60, xe, xc); chk("steady1_edge", xe, 47); chk("steady1_cmd", xc, 2);
        next_xfer(60, xe, xc); chk("steady2_edge", xe, 67); chk("steady2_cmd", xc, 2);
        next_xfer(60, xe, xc); chk("steady3_edge", xe, 87); chk("steady3_cmd", xc, 2);
        chk("steady_max_pending", max_pend, 1);

        // Async reset in WAIT_IRFC, then an identical init
        RST = 1'b1; release_rst();
        start_init();
        next_xfer(30, xe, xc);
        next_xfer(30, xe, xc);
        chk("rst_mid_iref_edge", xe, 15);
        step();
        #2 RST = 1'b1;
        #1 chk_all_zero("rst_irfc");
        release_rst();
        run_init("reinit");

        // Ready stall during PRE, then backlog with ready low
        RST = 1'b1; release_rst();
        cmd_ready = 1'b0;
        start_init();
        wait_valid();
        chk("stall_first_valid_edge", e, 11);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold", {cmd_valid, cmd}, 3'b101);
        end
        cmd_ready = 1'b1;
        next_xfer(20, xe, xc); chk("stall_pre_edge", xe, 17); chk("stall_pre_cmd", xc, 1);
        chk("stall_wait_rp_valid", cmd_valid, 0);
        next_xfer(20, xe, xc); chk("stall_iref1_edge", xe, 20);
        next_xfer(20, xe, xc); chk("stall_iref2_edge", xe, 24);
        next_xfer(20, xe, xc); chk("stall_lmr_edge", xe, 28); chk("stall_lmr_cmd", xc, 3);
        wait_init_done();
        chk("stall_init_done_edge", e, 31);
        cmd_ready = 1'b0;
        step_to(50);  chk("bk_tick1_pend", pending, 1);
        step_to(109); chk("bk_pre_tick4_pend", pending, 3);
        step_to(110); chk("bk_tick4_pend", pending, 4); chk("bk_tick4_ovf", overflow, 0);
        step_to(129); chk("bk_pre_tick5_ovf", overflow, 0);
        step_to(130); chk("bk_tick5_ovf", overflow, 1); chk("bk_tick5_pend", pending, 4);
        step_to(131);
        cmd_ready = 1'b1;
        next_xfer(20, xe, xc); chk("bk_drain1_edge", xe, 132); chk("bk_drain1_pend", pending, 3);
        next_xfer(20, xe, xc); chk("bk_drain2_edge", xe, 136); chk("bk_drain2_pend", pending, 2);
        next_xfer(20, xe, xc); chk("bk_drain3_edge", xe, 140); chk("bk_drain3_pend", pending, 1);
        next_xfer(20, xe, xc); chk("bk_drain4_edge", xe, 144); chk("bk_drain4_pend", pending, 0);
        chk("bk_ovf_sticky", overflow, 1);
        #2 RST = 1'b1;
        #1 chk_all_zero("rst_async");
        release_rst();

        // Tick and refresh transfer on the same edge
        cmd_ready = 1'b1;
        run_init("same");
        cmd_ready = 1'b0;
        step_to(64);
        chk("same_pre_pend", pending, 1);
        chk("same_pre_valid", cmd_valid, 1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("same_edge_pend", pending, 1);
        chk("same_edge_ovf", overflow, 0);
        chk("same_edge_valid", cmd_valid, 0);
        cmd_ready = 1'b1;
        next_xfer(20, xe, xc); chk("same_next_edge", xe, 69); chk("same_next_pend", pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
